// File: rtl/lsr_pipe.sv
// Purpose: pipelined logical-shift-right barrel shifter, one registered stage per shift level.
// Latency: LOG2W cycles from input transfer to O_valid; one result per cycle when unstalled.
// Backpressure: valid/ready chain; a stage advances when it is empty or the stage below advances.
module lsr_pipe #(
  parameter int WIDTH = 8,
  localparam int LOG2W = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] I,
  input  logic [LOG2W-1:0] S,
  input  logic             I_valid,
  output logic             I_ready,
  output logic [WIDTH-1:0] O,
  output logic             O_valid,
  input  logic             O_ready
);

  // Per-stage register outputs, gathered so the next stage can read them by index.
  logic [WIDTH-1:0] w_data [LOG2W];
  logic [LOG2W-1:0] w_sh   [LOG2W];
  logic             w_vld  [LOG2W];

  // Per-stage inputs (from I/S/I_valid for stage 0, from the previous stage otherwise).
  logic [WIDTH-1:0] w_d_in  [LOG2W];
  logic [LOG2W-1:0] w_sh_in [LOG2W];
  logic             w_v_in  [LOG2W];

  // Stage k may load this cycle.
  logic             w_rdy   [LOG2W];

  // The last stage's leftover shift bits are always zero and feed nothing.
  logic             w_unused;

  for (genvar k = 0; k < LOG2W; k++) begin : g_stage
    logic [WIDTH-1:0] r_data;
    logic [LOG2W-1:0] r_sh;
    logic             r_vld;
    logic [WIDTH-1:0] w_d_nxt;

    if (k == 0) begin : g_head
      assign w_d_in[k]  = I;
      assign w_sh_in[k] = S;
      assign w_v_in[k]  = I_valid;
    end else begin : g_body
      assign w_d_in[k]  = w_data[k-1];
      assign w_sh_in[k] = w_sh[k-1];
      assign w_v_in[k]  = w_vld[k-1];
    end

    // The output stage frees up when downstream takes it; earlier stages when the next one moves.
    if (k == LOG2W - 1) begin : g_tail
      assign w_rdy[k] = O_ready | ~r_vld;
    end else begin : g_mid
      assign w_rdy[k] = ~r_vld | w_rdy[k+1];
    end

    // Bit 0 of the incoming shift field always selects this stage's 2^k shift.
    assign w_d_nxt = w_sh_in[k][0] ? (w_d_in[k] >> (1 << k)) : w_d_in[k];

    // Valid bit: cleared by reset, otherwise follows upstream valid whenever the stage loads.
    always_ff @(posedge CLK) begin
      if (RESET) begin
        r_vld <= 1'b0;
      end else if (w_rdy[k]) begin
        r_vld <= w_v_in[k];
      end
    end

    // Data and remaining shift bits; consumed bit is dropped so the next level sees its bit at 0.
    always_ff @(posedge CLK) begin
      if (w_rdy[k]) begin
        r_data <= w_d_nxt;
        r_sh   <= w_sh_in[k] >> 1;
      end
    end

    assign w_data[k] = r_data;
    assign w_sh[k]   = r_sh;
    assign w_vld[k]  = r_vld;
  end

  assign w_unused = ^w_sh[LOG2W-1];

  assign I_ready = w_rdy[0];
  assign O       = w_data[LOG2W-1];
  assign O_valid = w_vld[LOG2W-1];

endmodule

// File: tb/tb_lsr_pipe.sv
// Directed and random checks of lsr_pipe at WIDTH=8 and WIDTH=4.
module tb_lsr_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] i8, o8;
  logic [2:0] s8;
  logic       iv8, ir8, ov8, or8;
  logic [3:0] i4, o4;
  logic [1:0] s4;
  logic       iv4, ir4, ov4, or4;

  lsr_pipe #(.WIDTH(8)) dut8 (
    .CLK(clk), .RESET(rst), .I(i8), .S(s8), .I_valid(iv8), .I_ready(ir8),
    .O(o8), .O_valid(ov8), .O_ready(or8)
  );

  lsr_pipe #(.WIDTH(4)) dut4 (
    .CLK(clk), .RESET(rst), .I(i4), .S(s4), .I_valid(iv4), .I_ready(ir4),
    .O(o4), .O_valid(ov4), .O_ready(or4)
  );

  typedef struct {
    logic [7:0] i;
    logic [2:0] s;
    logic [7:0] e;
  } vec8_t;

  typedef struct {
    logic [3:0] i;
    logic [1:0] s;
    logic [3:0] e;
  } vec4_t;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec8_t tab8[12];
    vec4_t tab4[4];
    logic [7:0] bp_i[5];
    logic [2:0] bp_s[5];
    logic [7:0] bp_e[5];
    logic [7:0] exp_q[$];
    int k, m, n_in, n_out;
    logic took, acc, done;

    tab8[0]  = '{8'hB4, 3'd0, 8'hB4};
    tab8[1]  = '{8'hB4, 3'd3, 8'h16};
    tab8[2]  = '{8'h80, 3'd7, 8'h01};
    tab8[3]  = '{8'hFF, 3'd4, 8'h0F};
    tab8[4]  = '{8'h5A, 3'd1, 8'h2D};
    tab8[5]  = '{8'h01, 3'd0, 8'h01};
    tab8[6]  = '{8'h01, 3'd1, 8'h00};
    tab8[7]  = '{8'hFF, 3'd7, 8'h01};
    tab8[8]  = '{8'hC3, 3'd2, 8'h30};
    tab8[9]  = '{8'hC3, 3'd6, 8'h03};
    tab8[10] = '{8'h7F, 3'd7, 8'h00};
    tab8[11] = '{8'hA5, 3'd5, 8'h05};

    tab4[0] = '{4'hA, 2'd0, 4'hA};
    tab4[1] = '{4'hA, 2'd1, 4'h5};
    tab4[2] = '{4'hA, 2'd2, 4'h2};
    tab4[3] = '{4'hA, 2'd3, 4'h1};

    bp_i[0] = 8'h81; bp_s[0] = 3'd0; bp_e[0] = 8'h81;
    bp_i[1] = 8'h82; bp_s[1] = 3'd1; bp_e[1] = 8'h41;
    bp_i[2] = 8'h84; bp_s[2] = 3'd2; bp_e[2] = 8'h21;
    bp_i[3] = 8'h88; bp_s[3] = 3'd3; bp_e[3] = 8'h11;
    bp_i[4] = 8'h90; bp_s[4] = 3'd4; bp_e[4] = 8'h09;

    rst = 1'b1;
    i8 = '0; s8 = '0; iv8 = 1'b0; or8 = 1'b1;
    i4 = '0; s4 = '0; iv4 = 1'b0; or4 = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
    chk("reset_ovalid8", 32'(ov8), 32'd0);
    chk("reset_iready8", 32'(ir8), 32'd1);
    chk("reset_ovalid4", 32'(ov4), 32'd0);
    chk("reset_iready4", 32'(ir4), 32'd1);

    // Single passthrough, latency exactly three cycles.
    i8 = 8'hB4; s8 = 3'd0; iv8 = 1'b1;
    step();
    iv8 = 1'b0;
    chk("pass_ov_c1", 32'(ov8), 32'd0);
    step();
    chk("pass_ov_c2", 32'(ov8), 32'd0);
    step();
    chk("pass_ov_c3", 32'(ov8), 32'd1);
    chk("pass_data", 32'(o8), 32'hB4);
    step();
    chk("pass_ov_c4", 32'(ov8), 32'd0);

    // Back-to-back table stream, O_ready held high.
    for (int cyc = 0; cyc <= 14; cyc++) begin
      if (cyc < 12) begin
        i8 = tab8[cyc].i; s8 = tab8[cyc].s; iv8 = 1'b1;
        #1;
        chk("tab_iready", 32'(ir8), 32'd1);
      end else begin
        iv8 = 1'b0;
      end
      step();
      if (cyc < 2 || cyc == 14) begin
        chk("tab_ov_idle", 32'(ov8), 32'd0);
      end else begin
        chk("tab_ov", 32'(ov8), 32'd1);
        chk("tab_data", 32'(o8), 32'(tab8[cyc-2].e));
      end
    end

    // Backpressure: three accepted while stalled, then release.
    or8 = 1'b0;
    k = 0;
    for (int c = 0; c < 5; c++) begin
      i8 = bp_i[k]; s8 = bp_s[k]; iv8 = 1'b1;
      #2;
      chk("bp_iready", 32'(ir8), 32'(c < 3));
      took = ir8;
      step();
      if (took) k++;
    end
    chk("bp_accepted", 32'(k), 32'd3);
    chk("bp_hold_ov", 32'(ov8), 32'd1);
    chk("bp_hold_data", 32'(o8), 32'h81);
    or8 = 1'b1;
    #2;
    chk("bp_release_iready", 32'(ir8), 32'd1);
    m = 0;
    done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      if (k < 5) begin
        i8 = bp_i[k]; s8 = bp_s[k]; iv8 = 1'b1;
      end else begin
        iv8 = 1'b0;
      end
      #2;
      acc = iv8 & ir8;
      if (ov8 && or8) begin
        chk("bp_data", 32'(o8), 32'(bp_e[m]));
        m++;
      end
      step();
      if (acc) k++;
      if (m == 5) done = 1'b1;
    end
    iv8 = 1'b0;
    chk("bp_delivered", 32'(m), 32'd5);
    chk("bp_consumed", 32'(k), 32'd5);
    step();
    chk("bp_no_dup", 32'(ov8), 32'd0);

    // Reset with three results in flight; a transfer offered during reset is discarded.
    or8 = 1'b1;
    for (int c = 0; c < 3; c++) begin
      i8 = 8'h11 * 8'(c + 1); s8 = 3'(c); iv8 = 1'b1;
      step();
    end
    rst = 1'b1;
    i8 = 8'hFF; s8 = 3'd0; iv8 = 1'b1;
    step();
    rst = 1'b0;
    iv8 = 1'b0;
    #1;
    chk("rst_ov", 32'(ov8), 32'd0);
    chk("rst_iready", 32'(ir8), 32'd1);
    i8 = 8'h0F; s8 = 3'd2; iv8 = 1'b1;
    step();
    iv8 = 1'b0;
    chk("rst_stale1", 32'(ov8), 32'd0);
    step();
    chk("rst_stale2", 32'(ov8), 32'd0);
    step();
    chk("rst_new_ov", 32'(ov8), 32'd1);
    chk("rst_new_data", 32'(o8), 32'h03);
    step();
    chk("rst_after_ov", 32'(ov8), 32'd0);

    // WIDTH=4 instance, two-cycle latency.
    for (int cyc = 0; cyc <= 4; cyc++) begin
      if (cyc < 4) begin
        i4 = tab4[cyc].i; s4 = tab4[cyc].s; iv4 = 1'b1;
      end else begin
        iv4 = 1'b0;
      end
      step();
      if (cyc == 0) begin
        chk("w4_ov_idle", 32'(ov4), 32'd0);
      end else begin
        chk("w4_ov", 32'(ov4), 32'd1);
        chk("w4_data", 32'(o4), 32'(tab4[cyc-1].e));
      end
    end
    iv4 = 1'b0;
    step();
    chk("w4_after_ov", 32'(ov4), 32'd0);

    // Random valid/ready traffic against an in-order scoreboard.
    n_in = 0;
    n_out = 0;
    iv8 = 1'b0;
    for (int cyc = 0; cyc < 20000 && n_out < 1000; cyc++) begin
      if (!iv8 && n_in < 1000 && $urandom_range(0, 3) != 0) begin
        i8 = 8'($urandom); s8 = 3'($urandom); iv8 = 1'b1;
      end
      or8 = ($urandom_range(0, 2) != 0);
      #2;
      acc = iv8 & ir8;
      if (acc) begin
        exp_q.push_back(i8 >> s8);
        n_in++;
      end
      if (ov8 && or8) begin
        if (exp_q.size() == 0) begin
          chk("rand_spurious", 32'd1, 32'd0);
        end else begin
          chk("rand_data", 32'(o8), 32'(exp_q.pop_front()));
        end
        n_out++;
      end
      step();
      if (acc) iv8 = 1'b0;
    end
    iv8 = 1'b0;
    chk("rand_count", 32'(n_out), 32'd1000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/lsr_pipe.md
Name: lsr_pipe

Overview:
- Pipelined logical-shift-right barrel shifter; the right-shift counterpart of the team's combinational left-shift barrel shifters (Mux2 ladder per shift level).
- One registered stage per shift level, so it runs at full clock on ice40 LUT fabric.
- valid/ready handshake on input and output, with stall propagation for streaming datapaths (e.g. normalisers, field extractors).
- Zeros are shifted in at the MSB end.

Parameters:
- WIDTH, 8, data width; power of 2, >= 2.
- LOG2W, derived = log2(WIDTH), number of shift-amount bits and pipeline stages; not overridable.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RESET  input  1  synchronous reset, active-high.
- I  input  WIDTH  operand.
- S  input  LOG2W  shift amount, 0..WIDTH-1.
- I_valid  input  1  I/S valid this cycle.
- I_ready  output  1  block accepts I/S this cycle.
- O  output  WIDTH  result, I >> S (logical).
- O_valid  output  1  O holds a result.
- O_ready  input  1  downstream accepts O this cycle.

Behaviour:
- Stage k (k = 0..LOG2W-1) registers:
  - data_k[WIDTH-1:0];
  - the remaining shift bits S[LOG2W-1:k+1];
  - valid_k.
- Stage k computes data_out = S[k] ? {2^k zeros, data_in[WIDTH-1:2^k]} : data_in.
  - Stage 0 input is I/S; stage k input is stage k-1's registers.
  - Shift levels are applied LSB first: stage 0 shifts by 1, stage 1 by 2, and so on.
- Outputs: O = data_(LOG2W-1), O_valid = valid_(LOG2W-1). O is don't-care when O_valid = 0; the bench checks O only when O_valid = 1.
- Ready chain (combinational):
  - ready_(LOG2W-1) = O_ready | ~valid_(LOG2W-1);
  - ready_k = ~valid_k | ready_(k+1);
  - I_ready = ready_0.
- Stage k loads when ready_k:
  - data/shift bits take the incoming values;
  - valid_k takes the upstream valid (I_valid for k = 0, valid_(k-1) otherwise).
  - When ready_k = 0, stage k holds all its registers.
- Transfer rules:
  - Input transfer occurs when I_valid & I_ready; output transfer when O_valid & O_ready.
  - I_valid with I_ready = 0 is not captured; upstream must hold I/S stable until the transfer.
  - I_ready may depend combinationally on O_ready; O_valid does not depend on I_valid.
- Latency and throughput:
  - Latency is exactly LOG2W cycles from input transfer to O_valid, when unstalled.
  - Throughput is 1 result per cycle with O_ready held high.
  - Capacity is LOG2W results. Results emerge in input order; none dropped or duplicated.
- Simultaneous events:
  - When full, O_ready = 1 frees the last stage and the whole chain advances in the same cycle, so I_ready = 1 that cycle.
  - O_ready = 0 with the pipeline not full: bubbles compress, and I_ready stays 1 until all stages are valid.
- Reset:
  - RESET = 1 at a clock edge clears all valid_k to 0. Data registers need not reset.
  - After that edge: O_valid = 0, I_ready = 1.
  - A transfer presented in the reset cycle is discarded.
  - Reset mid-stream discards all in-flight results; the first post-reset input emerges LOG2W cycles after its transfer.
- Arithmetic:
  - S = 0 passes I through unchanged.
  - S = WIDTH-1 leaves only the original MSB, at bit 0.
  - No sign extension; all vacated bits are 0.

Test Plan:
- Passthrough/latency (WIDTH=8): RESET then I=0xB4, S=0, one cycle valid, O_ready=1 -> O_valid=1 exactly 3 cycles later with O=0xB4; O_valid=0 before and after.
- Shift values: back-to-back I/S pairs (0xB4,3), (0x80,7), (0xFF,4), (0x5A,1), one per cycle, O_ready=1 -> O=0x16, 0x01, 0x0F, 0x2D on four consecutive cycles starting 3 cycles after the first input.
- Backpressure: O_ready=0, offer 5 inputs continuously -> first 3 accepted, I_ready=0 afterwards. Raise O_ready -> I_ready=1 the same cycle; all 5 results delivered in order, no loss or duplication.
- Random stall: random I_valid/O_ready, 1000 transactions -> scoreboard matches (I >> S) & mask, in order.
- Reset mid-operation: 3 results in flight, RESET for 1 cycle -> next cycle O_valid=0, I_ready=1. A new input I=0x0F, S=2 yields O=0x03 after 3 cycles; no stale results appear.
- WIDTH=4 instance: I=0xA, S=1..3 -> O = 0x5, 0x2, 0x1, each 2 cycles after its input.
